seq_mul_shift_add: RTL
======================

Name: seq_mul_shift_add

Overview:
- Multi-cycle unsigned shift-and-add multiplier for the RISC-V arithmetic datapath.
- Each cycle it feeds one partial product through a WIDTH-bit ripple adder built from the team's half/full adder cells, which sit directly downstream of its partial-product path.
- Gives a low-area M-extension MUL/MULHU path with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand width in bits (legal range >= 2); the product is 2*WIDTH bits.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_start  input  1  request valid; operands present on i_data_a/i_data_b
- o_ready  output  1  block can accept a request; equals (state==IDLE)
- i_data_a  input  WIDTH  multiplicand
- i_data_b  input  WIDTH  multiplier
- o_data  output  2*WIDTH  product; {hi,lo}
- o_valid  output  1  o_data holds a completed product
- i_ready  input  1  consumer accepts o_data
- o_busy  output  1  equals (state==CALC)

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset (i_rst_n=0), immediate and asynchronous:
  - state=IDLE, o_data=0, o_valid=0, o_busy=0, o_ready=1.
  - Internal accumulator, multiplicand register, multiplier register and counter all cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On a rising edge with i_start=1: capture the multiplicand into MCAND and the multiplier into the low half of ACC. Clear the high half and the carry bit. Set count=0. Go to CALC.
  - If i_start=0, remain in IDLE.
- CALC, one step per cycle:
  - If ACC[0]=1, compute {c, sum} = ACC[2W-1:W] + MCAND as a WIDTH+1-bit sum; otherwise {c, sum} = {0, ACC[2W-1:W]}.
  - Then ACC <= {c, sum, ACC[W-1:1]}, a 1-bit logical right shift with the carry entering the MSB.
  - count increments each step. At the step where count==WIDTH-1, the final ACC is written to o_data and the state moves to DONE.
- DONE:
  - o_valid=1 and o_data is held stable.
  - If i_ready=1 on an edge, go to IDLE and drop o_valid on the same edge.
  - With i_ready=0, DONE persists indefinitely and o_data does not change.
- Latency:
  - Request accepted at edge N: o_valid rises at edge N+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles. No acceptance is possible in the DONE->IDLE handoff cycle.
- i_start while not IDLE: ignored. The operands are not captured and are not queued.
- o_data after DONE->IDLE: keeps the last product until the next completion overwrites it. o_valid=0 marks it stale.
- i_ready while not in DONE: ignored.
- Arithmetic: the full 2*WIDTH product is exact; no overflow is possible. Edge operands need no special case:
  - operand 0 gives 0;
  - all-ones x all-ones gives 2^(2W) - 2^(W+1) + 1.
- Reset mid-CALC or mid-DONE: the operation is aborted, every output returns to its reset value, and nothing is emitted.

Optional Feature:
- Macro: SEQ_MUL_SIGNED_EN
- Defined: operands are two's complement.
  - At capture, the absolute values are loaded and neg = a[W-1]^b[W-1] is registered.
  - On the DONE write, o_data = neg ? -ACC : ACC, computed as a 2W-bit two's-complement negate in the same cycle, so latency is unchanged.
  - The most-negative operand's magnitude (2^(W-1)) fits in WIDTH bits unsigned; -2^(W-1) x -2^(W-1) = 2^(2W-2) is exact.
  - neg is cleared by reset.
- Undefined: purely unsigned. The neg register and negate logic are absent.

Test Plan:
- WIDTH=8, a=13, b=11, start at edge N, i_ready=1 -> o_valid at edge N+8, o_data=0x008F; o_busy=1 for edges N..N+7; o_ready=1 again after the accept edge.
- WIDTH=8, a=255, b=255 -> o_data=0xFE01. Then a=0, b=200 -> o_data=0x0000. Then a=1, b=128 -> o_data=0x0080.
- Backpressure: a=6, b=7 with i_ready=0 for 5 cycles after o_valid -> o_data=0x002A stable and o_valid=1 throughout. i_start pulsed with a=9 during DONE -> ignored. i_ready=1 -> IDLE.
- Reset mid-op: start a=100, b=3, drop i_rst_n at CALC step 4 -> all outputs 0 and o_ready=1 asynchronously. The next request a=2, b=3 -> o_data=0x0006.
- Back-to-back: two requests (5x5, then 10x10) each issued at the first cycle with o_ready=1 -> 0x0019 then 0x0064, with issue interval WIDTH+2.
- SEQ_MUL_SIGNED_EN, WIDTH=8:
  - -3 x 5 -> 0xFFF1
  - -128 x -128 -> 0x4000
  - 127 x -1 -> 0xFF81

Source files
------------

// File: rtl/seq_mul_shift_add.sv
// -----------------------------------------------------------------------------
// seq_mul_shift_add
//   Multi-cycle shift-and-add multiplier for the MUL/MULHU datapath. One partial
//   product per cycle is folded into the high half of a 2*WIDTH accumulator
//   through a WIDTH-bit ripple adder, then the accumulator shifts right by one.
//   A request accepted at edge N presents its product (o_valid) at edge N+WIDTH.
//
//   Optional build macro:
//     SEQ_MUL_SIGNED_EN - operands are two's complement. Magnitudes are
//                         multiplied and the sign is applied on the final write.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_start   request valid, operands on i_data_a / i_data_b
//   o_ready   idle, request can be accepted
//   i_data_a  multiplicand   [WIDTH-1:0]
//   i_data_b  multiplier     [WIDTH-1:0]
//   o_data    product {hi,lo} [2*WIDTH-1:0]
//   o_valid   o_data holds a completed product
//   i_ready   consumer accepts o_data
//   o_busy    multiplication in progress
// -----------------------------------------------------------------------------
module seq_mul_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_data_a,
  input  logic [WIDTH-1:0]     i_data_b,
  output logic [2*WIDTH-1:0]   o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry_out;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   a_load;
  logic [WIDTH-1:0]   b_load;
  logic               last_step;

  assign last_step = (count == CW'(WIDTH - 1));

  // Ripple adder of full-adder cells: high half of the accumulator plus the
  // gated multiplicand. Bit 0 has no carry-in, so it degenerates to a half adder.
  assign addend = acc[0] ? mcand : '0;

  always_comb begin
    logic c;
    // NOTE: every combinational output gets a value before any branch/loop so
    // no path leaves it unassigned; otherwise a latch is inferred.
    sum = '0;
    c   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = acc[WIDTH + i] ^ addend[i] ^ c;
      c      = (acc[WIDTH + i] & addend[i]) | (c & (acc[WIDTH + i] ^ addend[i]));
    end
    carry_out = c;
  end

  // Carry enters the MSB while the low half shifts out the consumed multiplier bit.
  assign acc_next = {carry_out, sum, acc[WIDTH-1:1]};

`ifdef SEQ_MUL_SIGNED_EN
  logic neg;

  // Magnitudes; the most-negative value maps to 2^(WIDTH-1), which fits unsigned.
  assign a_load = i_data_a[WIDTH-1] ? (~i_data_a + 1'b1) : i_data_a;
  assign b_load = i_data_b[WIDTH-1] ? (~i_data_b + 1'b1) : i_data_b;
  assign result = neg ? (~acc_next + 1'b1) : acc_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      neg <= 1'b0;
    end else if (state == IDLE && i_start) begin
      neg <= i_data_a[WIDTH-1] ^ i_data_b[WIDTH-1];
    end
  end
`else
  assign a_load = i_data_a;
  assign b_load = i_data_b;
  assign result = acc_next;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start)   state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (i_ready)   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      count  <= '0;
      o_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            mcand <= a_load;
            acc   <= {{WIDTH{1'b0}}, b_load};
            count <= '0;
          end
        end
        CALC: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (last_step) o_data <= result;
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (state == IDLE);
  assign o_busy  = (state == CALC);
  assign o_valid = (state == DONE);

endmodule
